// File: rtl/bram_uart_sender.sv
// -----------------------------------------------------------------------------
// bram_uart_sender
// Reads every stored pixel word out of the frame BRAM and streams it to the PC
// over an 8N1 UART. Stream: one sync byte, then per pixel {4'h0, R} followed by
// {G, B}, in ascending address order.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   start      in   level; a rising edge requests a transfer (accepted in IDLE/DONE)
//   abort      in   level; stop after the UART frame currently on the wire
//   bram_addr  out  BRAM read address
//   bram_dout  in   BRAM read data, RGB444 {R,G,B}, RD_LAT cycles after address
//   tx         out  UART serial line, idle high
//   busy       out  transfer in progress
//   done       out  last transfer completed; held until next accepted start or rst
// -----------------------------------------------------------------------------
module bram_uart_sender #(
   parameter int         CLKS_PER_BIT = 564,
   parameter int         ADDR_W       = 17,
   parameter int         NUM_WORDS    = 76800,
   parameter int         RD_LAT       = 2,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic [ADDR_W-1:0] bram_addr,
   input  logic [11:0]       bram_dout,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int RD_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [RD_W-1:0]   RD_LAST   = RD_W'(RD_LAT - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_WORDS - 1);

   typedef enum logic [2:0] {
      IDLE, SEND_SYNC, FETCH, WAIT_RD, SEND_HI, SEND_LO, DONE
   } state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [RD_W-1:0]   rd_cnt_reg, rd_cnt_next;
   logic              abort_pend_reg, abort_pend_next;
   logic              start_d_q;
   // Only the low byte of the fetched pixel needs holding: the high nibble is
   // handed to the UART directly from bram_dout in the same cycle it is latched.
   logic [7:0]        pix_q;
   logic              pix_load;

   // UART byte engine
   logic [9:0]        shift_reg;
   logic              frame_active_reg;
   logic [3:0]        bit_idx_reg;
   logic [BAUD_W-1:0] baud_cnt_reg;
   logic              byte_load;
   logic [7:0]        byte_data;
   logic              byte_sent;

   logic start_rise;
   logic abort_any;

   assign start_rise = start & ~start_d_q;
   // abort is a level that may be pulsed for a single cycle; remember it until
   // the frame on the wire has finished.
   assign abort_any  = abort | abort_pend_reg;
   assign byte_sent  = frame_active_reg && (bit_idx_reg == 4'd9) && (baud_cnt_reg == BAUD_LAST);

   assign bram_addr = addr_reg;
   assign busy      = (state_reg != IDLE) && (state_reg != DONE);
   assign done      = (state_reg == DONE);
   assign tx        = frame_active_reg ? shift_reg[0] : 1'b1;

   always_comb begin
      state_next      = state_reg;
      addr_next       = addr_reg;
      rd_cnt_next     = rd_cnt_reg;
      abort_pend_next = abort_pend_reg;
      pix_load        = 1'b0;
      byte_load       = 1'b0;
      byte_data       = SYNC_BYTE;
      case (state_reg)
         IDLE, DONE: begin
            abort_pend_next = 1'b0;
            // abort beats a simultaneous start edge
            if (start_rise && !abort) begin
               state_next = SEND_SYNC;
               addr_next  = '0;
               byte_load  = 1'b1;
               byte_data  = SYNC_BYTE;
            end
         end
         SEND_SYNC: begin
            abort_pend_next = abort_any;
            if (byte_sent) begin
               if (abort_any) begin
                  state_next      = IDLE;
                  addr_next       = '0;
                  abort_pend_next = 1'b0;
               end else begin
                  state_next = FETCH;
               end
            end
         end
         FETCH: begin
            if (abort_any) begin
               state_next      = IDLE;
               addr_next       = '0;
               abort_pend_next = 1'b0;
            end else begin
               rd_cnt_next = '0;
               state_next  = WAIT_RD;
            end
         end
         WAIT_RD: begin
            if (abort_any) begin
               state_next      = IDLE;
               addr_next       = '0;
               abort_pend_next = 1'b0;
            end else if (rd_cnt_reg == RD_LAST) begin
               pix_load   = 1'b1;
               byte_load  = 1'b1;
               byte_data  = {4'h0, bram_dout[11:8]};
               state_next = SEND_HI;
            end else begin
               rd_cnt_next = rd_cnt_reg + RD_W'(1);
            end
         end
         SEND_HI: begin
            abort_pend_next = abort_any;
            if (byte_sent) begin
               if (abort_any) begin
                  state_next      = IDLE;
                  addr_next       = '0;
                  abort_pend_next = 1'b0;
               end else begin
                  // load at the stop-bit edge so the next start bit follows directly
                  byte_load  = 1'b1;
                  byte_data  = pix_q;
                  state_next = SEND_LO;
               end
            end
         end
         SEND_LO: begin
            abort_pend_next = abort_any;
            if (byte_sent) begin
               if (abort_any) begin
                  state_next      = IDLE;
                  addr_next       = '0;
                  abort_pend_next = 1'b0;
               end else if (addr_reg == ADDR_LAST) begin
                  state_next = DONE;
               end else begin
                  addr_next  = addr_reg + ADDR_W'(1);
                  state_next = FETCH;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         addr_reg       <= '0;
         rd_cnt_reg     <= '0;
         abort_pend_reg <= 1'b0;
         // a start already high when reset releases must not count as an edge
         start_d_q      <= 1'b1;
         pix_q          <= '0;
      end else begin
         state_reg      <= state_next;
         addr_reg       <= addr_next;
         rd_cnt_reg     <= rd_cnt_next;
         abort_pend_reg <= abort_pend_next;
         start_d_q      <= start;
         if (pix_load) begin
            pix_q <= bram_dout[7:0];
         end
      end
   end

   // Frame layout in shift_reg (LSB goes out first): start 0, d0..d7, stop 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_active_reg <= 1'b0;
         shift_reg        <= '1;
         bit_idx_reg      <= '0;
         baud_cnt_reg     <= '0;
      end else if (byte_load) begin
         frame_active_reg <= 1'b1;
         shift_reg        <= {1'b1, byte_data, 1'b0};
         bit_idx_reg      <= '0;
         baud_cnt_reg     <= '0;
      end else if (frame_active_reg) begin
         if (baud_cnt_reg == BAUD_LAST) begin
            baud_cnt_reg <= '0;
            if (bit_idx_reg == 4'd9) begin
               frame_active_reg <= 1'b0;
            end else begin
               bit_idx_reg <= bit_idx_reg + 4'd1;
               shift_reg   <= {1'b1, shift_reg[9:1]};
            end
         end else begin
            baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_bram_uart_sender.sv
// -----------------------------------------------------------------------------
// tb_bram_uart_sender
// Self-checking bench for bram_uart_sender with a small 3-word BRAM model.
// A negedge UART monitor decodes frames from tx into rx_q; each scenario task
// compares rx_q with a byte stream built directly from the BRAM contents.
// -----------------------------------------------------------------------------
module tb_bram_uart_sender;

   localparam int CPB   = 4;
   localparam int NW    = 3;
   localparam int RDL   = 2;
   localparam int AW    = 17;
   localparam int FRAME = 10 * CPB;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          abort;
   logic [AW-1:0] bram_addr;
   logic [11:0]   bram_dout;
   logic          tx;
   logic          busy;
   logic          done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [11:0]   mem [0:NW-1];
   logic [11:0]   rd_pipe;
   logic [7:0]    rx_q[$];
   logic [7:0]    exp_q[$];
   logic [AW-1:0] addr_log[$];
   logic          in_frame = 1'b0;
   int            frame_idx = 0;
   logic [FRAME-1:0] frame_bits;

   always #5 clk = ~clk;

   bram_uart_sender #(
      .CLKS_PER_BIT(CPB),
      .ADDR_W      (AW),
      .NUM_WORDS   (NW),
      .RD_LAT      (RDL),
      .SYNC_BYTE   (8'hA5)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .bram_addr(bram_addr),
      .bram_dout(bram_dout),
      .tx       (tx),
      .busy     (busy),
      .done     (done)
   );

   // BRAM with two registered stages: data appears RDL cycles after the address
   always @(posedge clk) begin
      if (bram_addr < AW'(NW)) rd_pipe <= mem[bram_addr[1:0]];
      else                     rd_pipe <= 12'h000;
      bram_dout <= rd_pipe;
   end

   // UART monitor: a 0 outside a frame starts one; every bit must hold for CPB cycles
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            in_frame  = 1'b0;
            frame_idx = 0;
         end else begin
            if (busy === 1'b1 && (addr_log.size() == 0 || addr_log[$] != bram_addr))
               addr_log.push_back(bram_addr);
            if (!in_frame && tx === 1'b0) begin
               in_frame  = 1'b1;
               frame_idx = 0;
            end
            if (in_frame) begin
               frame_bits[frame_idx] = tx;
               frame_idx++;
               if (frame_idx == FRAME) begin
                  bit shape_ok;
                  logic [7:0] b;
                  in_frame = 1'b0;
                  shape_ok = 1'b1;
                  for (int k = 0; k < 10; k++)
                     for (int j = 1; j < CPB; j++)
                        if (frame_bits[k*CPB+j] !== frame_bits[k*CPB]) shape_ok = 1'b0;
                  if (frame_bits[0] !== 1'b0) shape_ok = 1'b0;
                  if (frame_bits[9*CPB] !== 1'b1) shape_ok = 1'b0;
                  for (int i = 0; i < 8; i++) b[i] = frame_bits[(i+1)*CPB];
                  n_checks++;
                  if (!shape_ok) begin
                     n_fail++;
                     $display("FAIL frame_shape: got samples %b, required start 0, stop 1, %0d-cycle bits",
                              frame_bits, CPB);
                  end
                  rx_q.push_back(b);
               end
            end
         end
      end
   end

   task automatic preload();
      mem[0] = 12'h123;
      mem[1] = 12'hABC;
      mem[2] = 12'hF0F;
   endtask

   // Reference stream: sync byte, then {0,R} and {G,B} per word
   task automatic build_expected();
      exp_q.delete();
      exp_q.push_back(8'hA5);
      for (int w = 0; w < NW; w++) begin
         exp_q.push_back({4'h0, mem[w][11:8]});
         exp_q.push_back(mem[w][7:0]);
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1 start = 1'b1;
   endtask

   task automatic wait_rx(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (rx_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; abort = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b, expected 1", tx); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, expected 0", done); end
      n_checks++; if (bram_addr !== AW'(0)) begin n_fail++; $display("FAIL reset_addr: got %0d, expected 0", bram_addr); end
      rx_q.delete();
      repeat (20) @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL held_start_busy: got %b, expected 0", busy); end
      n_checks++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL held_start_bytes: got %0d, expected 0", rx_q.size()); end
      $display("txn reset: busy=%b done=%b tx=%b", busy, done, tx);
   endtask

   task automatic test_transfer();
      bit ok;
      preload();
      build_expected();
      rx_q.delete();
      addr_log.delete();
      pulse_start();
      wait_rx(7, 2000, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL transfer_timeout: got %0d bytes, expected 7", rx_q.size()); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL last_stop_busy: got %b, expected 1", busy); end
      @(negedge clk);
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL transfer_done: got %b, expected 1", done); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL transfer_busy: got %b, expected 0", busy); end
      n_checks++; if (bram_addr !== AW'(NW-1)) begin n_fail++; $display("FAIL done_addr: got %0d, expected %0d", bram_addr, NW-1); end
      n_checks++;
      if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL transfer_count: got %0d, expected %0d", rx_q.size(), exp_q.size()); end
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL transfer_byte%0d: got %h, expected %h", i, rx_q[i], exp_q[i]); end
      end
      n_checks++;
      if (addr_log.size() != NW) begin n_fail++; $display("FAIL addr_seq_len: got %0d, expected %0d", addr_log.size(), NW); end
      for (int i = 0; i < addr_log.size() && i < NW; i++) begin
         n_checks++;
         if (addr_log[i] !== AW'(i)) begin n_fail++; $display("FAIL addr_seq%0d: got %0d, expected %0d", i, addr_log[i], i); end
      end
      $display("txn transfer: bytes=%0d done=%b", rx_q.size(), done);
   endtask

   task automatic test_back_to_back();
      bit ok;
      preload();
      build_expected();
      rx_q.delete();
      pulse_start();
      repeat (60) @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk); #1 start = 1'b1;
      wait_rx(7, 2000, ok);
      repeat (100) @(negedge clk);
      n_checks++; if (rx_q.size() != 7) begin n_fail++; $display("FAIL ignored_start_count: got %0d, expected 7", rx_q.size()); end
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ignored_start_done: got %b, expected 1", done); end
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ignored_start_byte%0d: got %h, expected %h", i, rx_q[i], exp_q[i]); end
      end
      $display("txn ignored_start: bytes=%0d done=%b", rx_q.size(), done);
      rx_q.delete();
      pulse_start();
      @(negedge clk);
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL restart_pre_done: got %b, expected 1", done); end
      @(negedge clk);
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL restart_done_drop: got %b, expected 0", done); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy: got %b, expected 1", busy); end
      wait_rx(7, 2000, ok);
      repeat (10) @(negedge clk);
      n_checks++;
      if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL restart_count: got %0d, expected %0d", rx_q.size(), exp_q.size()); end
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL restart_byte%0d: got %h, expected %h", i, rx_q[i], exp_q[i]); end
      end
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL restart_done: got %b, expected 1", done); end
      $display("txn restart: bytes=%0d done=%b", rx_q.size(), done);
   endtask

   task automatic test_abort();
      bit ok;
      preload();
      rx_q.delete();
      pulse_start();
      wait_rx(2, 2000, ok);
      repeat (10) @(negedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      repeat (120) @(negedge clk);
      n_checks++; if (rx_q.size() != 3) begin n_fail++; $display("FAIL abort_count: got %0d, expected 3", rx_q.size()); end
      n_checks++;
      if (rx_q.size() >= 3 && rx_q[2] !== 8'h23) begin n_fail++; $display("FAIL abort_last_byte: got %h, expected 23", rx_q[2]); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b, expected 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b, expected 0", done); end
      n_checks++; if (bram_addr !== AW'(0)) begin n_fail++; $display("FAIL abort_addr: got %0d, expected 0", bram_addr); end
      $display("txn abort: bytes=%0d busy=%b done=%b", rx_q.size(), busy, done);
   endtask

   task automatic test_reset_mid();
      bit ok;
      preload();
      build_expected();
      rx_q.delete();
      pulse_start();
      wait_rx(3, 2000, ok);
      repeat (10) @(negedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL midrst_tx: got %b, expected 1", tx); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b, expected 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b, expected 0", done); end
      n_checks++; if (rx_q.size() != 3) begin n_fail++; $display("FAIL midrst_count: got %0d, expected 3", rx_q.size()); end
      #1 rst = 1'b0;
      rx_q.delete();
      pulse_start();
      wait_rx(7, 2000, ok);
      repeat (10) @(negedge clk);
      n_checks++;
      if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL midrst_resend_count: got %0d, expected %0d", rx_q.size(), exp_q.size()); end
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_byte%0d: got %h, expected %h", i, rx_q[i], exp_q[i]); end
      end
      $display("txn reset_mid: resent bytes=%0d", rx_q.size());
   endtask

   // Random BRAM contents and a random abort instant; the expected output is
   // the prefix of the full stream up to and including the frame on the wire.
   task automatic test_random_abort();
      for (int it = 0; it < 6; it++) begin
         int  dly;
         int  exp_n;
         bit  aborted;
         for (int w = 0; w < NW; w++) mem[w] = 12'($urandom);
         build_expected();
         rx_q.delete();
         pulse_start();
         dly = $urandom_range(0, 320);
         repeat (dly) @(negedge clk);
         if (dly == 0) @(negedge clk);
         #1;
         aborted = (busy === 1'b1);
         exp_n   = aborted ? (rx_q.size() + (in_frame ? 1 : 0)) : exp_q.size();
         if (aborted) begin
            abort = 1'b1;
            @(posedge clk); #1 abort = 1'b0;
         end
         repeat (400) @(negedge clk);
         n_checks++;
         if (rx_q.size() != exp_n) begin n_fail++; $display("FAIL rand%0d_count: got %0d, expected %0d", it, rx_q.size(), exp_n); end
         for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_byte%0d: got %h, expected %h", it, i, rx_q[i], exp_q[i]); end
         end
         n_checks++;
         if (done !== !aborted) begin n_fail++; $display("FAIL rand%0d_done: got %b, expected %b", it, done, !aborted); end
         n_checks++;
         if (busy !== 1'b0) begin n_fail++; $display("FAIL rand%0d_busy: got %b, expected 0", it, busy); end
         $display("txn random %0d: delay=%0d aborted=%0d bytes=%0d", it, dly, aborted, rx_q.size());
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b1;
      abort = 1'b0;
      test_reset();
      test_transfer();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      test_random_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
